// File: rtl/pdu_rb_ctrl.sv
// Ring-buffer controller for the PCIe PDU buffer: owns tail/head, hands pdu_gen its base, emits DMA descriptors.
// Latency: update pulse -> new tail/base/descriptor visible 2 cycles later; release -> occupancy 1 cycle later.
// Backpressure: registered almost_full throttles pdu_gen; descriptor FIFO stalls on desc_ready, overflow is dropped and flagged.
module pdu_rb_ctrl #(
  parameter int PDU_AWIDTH    = 12,
  parameter int MAX_PDU_FLITS = 25,
  parameter int DESC_DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PDU_AWIDTH-1:0] pcie_rb_wr_base_addr,
  output logic                  pcie_rb_wr_base_addr_valid,
  output logic                  pcie_rb_almost_full,
  input  logic                  pcie_rb_update_valid,
  input  logic [PDU_AWIDTH-1:0] pcie_rb_update_size,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [PDU_AWIDTH-1:0] desc_addr,
  output logic [PDU_AWIDTH-1:0] desc_size,
  input  logic                  rd_release_valid,
  input  logic [PDU_AWIDTH-1:0] rd_release_size,
  output logic [PDU_AWIDTH:0]   occupancy,
  output logic [2:0]            err_sticky
);

  localparam int AW = PDU_AWIDTH;
  localparam int DW = $clog2(DESC_DEPTH);

  // Thresholds pre-sized to the pointer/count widths so compares stay width-matched.
  localparam logic [AW:0] RING_FLITS = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] MAX_W      = (AW+1)'(MAX_PDU_FLITS);
  localparam logic [DW:0] CNT_AF     = (DW+1)'(DESC_DEPTH - 1);
  localparam logic [DW:0] CNT_FULL   = {1'b1, {DW{1'b0}}};

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_COMMIT} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [AW-1:0] size;
  } desc_t;

  state_t        state_q, state_d;
  logic [AW-1:0] size_q, size_d;
  logic [AW:0]   tail_q, tail_d;
  logic [AW:0]   head_q, head_d;
  logic [2:0]    err_q, err_d;
  logic          af_q, af_d;
  logic [DW:0]   wr_ptr_q, wr_ptr_d;
  logic [DW:0]   rd_ptr_q, rd_ptr_d;
  desc_t         mem_q [DESC_DEPTH];

  logic          push_vld;
  desc_t         push_dat;
  logic          pop_vld;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   occ_q;
  logic [AW:0]   occ_d;
  logic [AW:0]   free_d;
  logic [DW:0]   cnt_d;
  desc_t         head_ent;

  assign occ_q      = tail_q - head_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == CNT_FULL);
  assign pop_vld    = !fifo_empty && desc_ready;
  assign push_dat   = '{addr: tail_q[AW-1:0], size: size_q};
  assign head_ent   = mem_q[rd_ptr_q[DW-1:0]];

  // FSM next state, commit of the latched size, release handling and sticky errors.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    tail_d   = tail_q;
    head_d   = head_q;
    err_d    = err_q;
    push_vld = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (pcie_rb_update_valid) begin
          size_d  = pcie_rb_update_size;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        // A second update before we are back in IDLE is a protocol violation.
        if (pcie_rb_update_valid) err_d[2] = 1'b1;
        if (size_q == '0) begin
          err_d[2] = 1'b1;
        end else begin
          if ({1'b0, size_q} > MAX_W) err_d[2] = 1'b1;
          // Tail always advances so the ring matches what pdu_gen already wrote.
          tail_d = tail_q + {1'b0, size_q};
          if (fifo_full) err_d[0] = 1'b1;
          else           push_vld = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    // Release is judged against the current occupancy, independent of any commit this cycle.
    if (rd_release_valid) begin
      if ({1'b0, rd_release_size} <= occ_q) head_d = head_q + {1'b0, rd_release_size};
      else                                  err_d[1] = 1'b1;
    end
  end

  // Descriptor FIFO pointer advance and almost-full from next-cycle state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_vld) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_vld)  rd_ptr_d = rd_ptr_q + 1'b1;
    occ_d  = tail_d - head_d;
    free_d = RING_FLITS - occ_d;
    cnt_d  = wr_ptr_d - rd_ptr_d;
    af_d   = (free_d < MAX_W) || (cnt_d >= CNT_AF);
  end

  // State, pointer and flag registers; almost_full holds high through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      size_q   <= '0;
      tail_q   <= '0;
      head_q   <= '0;
      err_q    <= '0;
      af_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      tail_q   <= tail_d;
      head_q   <= head_d;
      err_q    <= err_d;
      af_q     <= af_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Descriptor storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_ptr_q[DW-1:0]] <= push_dat;
  end

  assign pcie_rb_wr_base_addr       = tail_q[AW-1:0];
  assign pcie_rb_wr_base_addr_valid = (state_q == ST_IDLE) && !pcie_rb_update_valid;
  assign pcie_rb_almost_full        = af_q;
  assign desc_valid                 = !fifo_empty;
  assign desc_addr                  = fifo_empty ? '0 : head_ent.addr;
  assign desc_size                  = fifo_empty ? '0 : head_ent.size;
  assign occupancy                  = occ_q;
  assign err_sticky                 = err_q;

endmodule

// File: tb/tb_pdu_rb_ctrl.sv
// Directed bench for pdu_rb_ctrl with hand-computed expectations (PDU_AWIDTH=12).
module tb_pdu_rb_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] base_addr;
  logic        base_vld;
  logic        af;
  logic        upd_vld;
  logic [11:0] upd_size;
  logic        desc_valid;
  logic        desc_ready;
  logic [11:0] desc_addr;
  logic [11:0] desc_size;
  logic        rel_vld;
  logic [11:0] rel_size;
  logic [12:0] occupancy;
  logic [2:0]  err;

  int n_vec = 0;
  int n_err = 0;

  pdu_rb_ctrl dut (
    .clk                        (clk),
    .rst                        (rst),
    .pcie_rb_wr_base_addr       (base_addr),
    .pcie_rb_wr_base_addr_valid (base_vld),
    .pcie_rb_almost_full        (af),
    .pcie_rb_update_valid       (upd_vld),
    .pcie_rb_update_size        (upd_size),
    .desc_valid                 (desc_valid),
    .desc_ready                 (desc_ready),
    .desc_addr                  (desc_addr),
    .desc_size                  (desc_size),
    .rd_release_valid           (rel_vld),
    .rd_release_size            (rel_size),
    .occupancy                  (occupancy),
    .err_sticky                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit(input logic [11:0] sz);
    upd_vld  = 1'b1;
    upd_size = sz;
    tick();
    upd_vld  = 1'b0;
    tick();
  endtask

  task automatic do_release(input logic [11:0] sz);
    rel_vld  = 1'b1;
    rel_size = sz;
    tick();
    rel_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_vld = 1'b0; upd_size = '0; desc_ready = 1'b1; rel_vld = 1'b0; rel_size = '0;
    repeat (3) tick();
    n_vec++; if (base_addr !== 12'd0) begin n_err++; $display("FAIL rst_base_addr got %0d want 0", base_addr); end
    n_vec++; if (base_vld !== 1'b0) begin n_err++; $display("FAIL rst_base_vld got %b want 0", base_vld); end
    n_vec++; if (af !== 1'b1) begin n_err++; $display("FAIL rst_almost_full got %b want 1", af); end
    n_vec++; if (desc_valid !== 1'b0) begin n_err++; $display("FAIL rst_desc_valid got %b want 0", desc_valid); end
    n_vec++; if (desc_addr !== 12'd0 || desc_size !== 12'd0) begin n_err++; $display("FAIL rst_desc got %0d/%0d want 0/0", desc_addr, desc_size); end
    n_vec++; if (occupancy !== 13'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    n_vec++; if (err !== 3'b000) begin n_err++; $display("FAIL rst_err got %b want 000", err); end
    rst = 1'b0;
    tick();
    n_vec++; if (base_vld !== 1'b1) begin n_err++; $display("FAIL edge1_base_vld got %b want 1", base_vld); end
    n_vec++; if (af !== 1'b0) begin n_err++; $display("FAIL edge1_almost_full got %b want 0", af); end
  endtask

  task automatic test_single_commit();
    upd_vld = 1'b1; upd_size = 12'd3;
    #1;
    n_vec++; if (base_vld !== 1'b0) begin n_err++; $display("FAIL commit_vld_T got %b want 0", base_vld); end
    tick();
    upd_vld = 1'b0;
    n_vec++; if (base_vld !== 1'b0) begin n_err++; $display("FAIL commit_vld_T1 got %b want 0", base_vld); end
    n_vec++; if (base_addr !== 12'd0) begin n_err++; $display("FAIL commit_base_T1 got %0d want 0", base_addr); end
    tick();
    n_vec++; if (base_vld !== 1'b1) begin n_err++; $display("FAIL commit_vld_T2 got %b want 1", base_vld); end
    n_vec++; if (base_addr !== 12'd3) begin n_err++; $display("FAIL commit_base_T2 got %0d want 3", base_addr); end
    n_vec++; if (desc_valid !== 1'b1 || desc_addr !== 12'd0 || desc_size !== 12'd3) begin
      n_err++; $display("FAIL commit_desc got v%b %0d/%0d want v1 0/3", desc_valid, desc_addr, desc_size); end
    n_vec++; if (occupancy !== 13'd3) begin n_err++; $display("FAIL commit_occ got %0d want 3", occupancy); end
    do_release(12'd3);
    n_vec++; if (occupancy !== 13'd0) begin n_err++; $display("FAIL release_occ got %0d want 0", occupancy); end
    n_vec++; if (desc_valid !== 1'b0) begin n_err++; $display("FAIL desc_popped got %b want 0", desc_valid); end
  endtask

  task automatic test_wrap();
    // From tail 3: 163*25 + 16 = 4091 flits brings the tail to 4094.
    for (int i = 0; i < 163; i++) begin
      do_commit(12'd25);
      do_release(12'd25);
    end
    do_commit(12'd16);
    do_release(12'd16);
    n_vec++; if (base_addr !== 12'd4094) begin n_err++; $display("FAIL wrap_pre_base got %0d want 4094", base_addr); end
    n_vec++; if (occupancy !== 13'd0) begin n_err++; $display("FAIL wrap_pre_occ got %0d want 0", occupancy); end
    do_commit(12'd5);
    n_vec++; if (base_addr !== 12'd3) begin n_err++; $display("FAIL wrap_base got %0d want 3", base_addr); end
    n_vec++; if (desc_valid !== 1'b1 || desc_addr !== 12'd4094 || desc_size !== 12'd5) begin
      n_err++; $display("FAIL wrap_desc got v%b %0d/%0d want v1 4094/5", desc_valid, desc_addr, desc_size); end
    n_vec++; if (occupancy !== 13'd5) begin n_err++; $display("FAIL wrap_occ got %0d want 5", occupancy); end
    do_release(12'd5);
  endtask

  task automatic test_almost_full();
    for (int i = 0; i < 162; i++) do_commit(12'd25);
    n_vec++; if (occupancy !== 13'd4050) begin n_err++; $display("FAIL af_occ4050 got %0d want 4050", occupancy); end
    n_vec++; if (af !== 1'b0) begin n_err++; $display("FAIL af_free46 got %b want 0", af); end
    do_commit(12'd22);
    n_vec++; if (occupancy !== 13'd4072) begin n_err++; $display("FAIL af_occ4072 got %0d want 4072", occupancy); end
    n_vec++; if (af !== 1'b1) begin n_err++; $display("FAIL af_free24 got %b want 1", af); end
    do_release(12'd1);
    n_vec++; if (occupancy !== 13'd4071) begin n_err++; $display("FAIL af_occ4071 got %0d want 4071", occupancy); end
    n_vec++; if (af !== 1'b0) begin n_err++; $display("FAIL af_free25 got %b want 0", af); end
    do_release(12'd4071);
    n_vec++; if (occupancy !== 13'd0) begin n_err++; $display("FAIL af_drain_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_fifo_full();
    // Tail is 8171 (low 12 bits 4075) on entry.
    desc_ready = 1'b0;
    for (int i = 0; i < 14; i++) do_commit(12'd1);
    n_vec++; if (af !== 1'b0) begin n_err++; $display("FAIL ff_cnt14_af got %b want 0", af); end
    do_commit(12'd1);
    n_vec++; if (af !== 1'b1) begin n_err++; $display("FAIL ff_cnt15_af got %b want 1", af); end
    do_commit(12'd1);
    n_vec++; if (err !== 3'b000) begin n_err++; $display("FAIL ff_cnt16_err got %b want 000", err); end
    do_commit(12'd1);
    n_vec++; if (err !== 3'b001) begin n_err++; $display("FAIL ff_overflow_err got %b want 001", err); end
    n_vec++; if (base_addr !== 12'd4092) begin n_err++; $display("FAIL ff_tail_adv got %0d want 4092", base_addr); end
    n_vec++; if (occupancy !== 13'd17) begin n_err++; $display("FAIL ff_occ got %0d want 17", occupancy); end
    n_vec++; if (desc_addr !== 12'd4075 || desc_size !== 12'd1) begin
      n_err++; $display("FAIL ff_head_desc got %0d/%0d want 4075/1", desc_addr, desc_size); end
    desc_ready = 1'b1;
    repeat (16) tick();
    n_vec++; if (desc_valid !== 1'b0) begin n_err++; $display("FAIL ff_drained got %b want 0", desc_valid); end
    n_vec++; if (af !== 1'b0) begin n_err++; $display("FAIL ff_drained_af got %b want 0", af); end
    do_release(12'd17);
  endtask

  task automatic test_back_to_back();
    do_commit(12'd10);
    n_vec++; if (occupancy !== 13'd10 || base_addr !== 12'd6) begin
      n_err++; $display("FAIL b2b_setup got occ %0d base %0d want 10/6", occupancy, base_addr); end
    upd_vld = 1'b1; upd_size = 12'd4;
    tick();
    upd_vld = 1'b0; rel_vld = 1'b1; rel_size = 12'd2;
    tick();
    rel_vld = 1'b0;
    n_vec++; if (occupancy !== 13'd12) begin n_err++; $display("FAIL b2b_occ got %0d want 12", occupancy); end
    n_vec++; if (base_addr !== 12'd10) begin n_err++; $display("FAIL b2b_base got %0d want 10", base_addr); end
    n_vec++; if (desc_valid !== 1'b1 || desc_addr !== 12'd6 || desc_size !== 12'd4) begin
      n_err++; $display("FAIL b2b_desc got v%b %0d/%0d want v1 6/4", desc_valid, desc_addr, desc_size); end
    do_release(12'd20);
    n_vec++; if (occupancy !== 13'd12) begin n_err++; $display("FAIL underflow_occ got %0d want 12", occupancy); end
    n_vec++; if (err !== 3'b011) begin n_err++; $display("FAIL underflow_err got %b want 011", err); end
  endtask

  task automatic test_reset_mid_commit();
    upd_vld = 1'b1; upd_size = 12'd7;
    tick();
    upd_vld = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++; if (base_addr !== 12'd0 || base_vld !== 1'b0) begin
      n_err++; $display("FAIL midrst_base got %0d v%b want 0 v0", base_addr, base_vld); end
    n_vec++; if (af !== 1'b1) begin n_err++; $display("FAIL midrst_af got %b want 1", af); end
    n_vec++; if (desc_valid !== 1'b0 || desc_addr !== 12'd0 || desc_size !== 12'd0) begin
      n_err++; $display("FAIL midrst_desc got v%b %0d/%0d want v0 0/0", desc_valid, desc_addr, desc_size); end
    n_vec++; if (occupancy !== 13'd0 || err !== 3'b000) begin
      n_err++; $display("FAIL midrst_occ_err got %0d/%b want 0/000", occupancy, err); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_vec++; if (base_vld !== 1'b1 || af !== 1'b0) begin
      n_err++; $display("FAIL recover got v%b af%b want v1 af0", base_vld, af); end
    do_commit(12'd0);
    n_vec++; if (err !== 3'b100) begin n_err++; $display("FAIL size0_err got %b want 100", err); end
    n_vec++; if (desc_valid !== 1'b0 || occupancy !== 13'd0 || base_addr !== 12'd0) begin
      n_err++; $display("FAIL size0_noop got v%b occ %0d base %0d want v0 0 0", desc_valid, occupancy, base_addr); end
    desc_ready = 1'b0;
    do_commit(12'd30);
    n_vec++; if (base_addr !== 12'd30 || occupancy !== 13'd30) begin
      n_err++; $display("FAIL oversize_commit got base %0d occ %0d want 30/30", base_addr, occupancy); end
    n_vec++; if (desc_valid !== 1'b1 || desc_addr !== 12'd0 || desc_size !== 12'd30) begin
      n_err++; $display("FAIL oversize_desc got v%b %0d/%0d want v1 0/30", desc_valid, desc_addr, desc_size); end
    n_vec++; if (err !== 3'b100) begin n_err++; $display("FAIL oversize_err got %b want 100", err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_commit();
    test_wrap();
    test_almost_full();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_commit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
